// File: rtl/char_grid_feature_pkg.sv
// Shared constants, FSM state type and feature-bit index helper for char_grid_feature.
package char_grid_feature_pkg;

  localparam int unsigned GRID_COLS = 5;
  localparam int unsigned GRID_ROWS = 8;
  localparam int unsigned FEAT_W    = 40;
  localparam int unsigned BIT_W     = $clog2(FEAT_W);
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BOX,
    SCAN,
    DONE
  } state_t;

  // Cell (r, c) maps to bit 39 - (5r + c); row 0 / col 0 is the MSB.
  function automatic int unsigned bit_idx(input int unsigned r, input int unsigned c);
    return FEAT_W - 1 - (GRID_COLS * r + c);
  endfunction

endpackage

// File: rtl/char_grid_feature_if.sv
// Pixel-stream, bounding-box and feature-result bundle for char_grid_feature.
interface char_grid_feature_if
  import char_grid_feature_pkg::*;
#(
  parameter int unsigned COORD_W = 12
);

  logic               i_vsync_pos;
  logic               i_de;
  logic               i_bin;
  logic [COORD_W-1:0] i_box_xmin;
  logic [COORD_W-1:0] i_box_xmax;
  logic [COORD_W-1:0] i_box_ymin;
  logic [COORD_W-1:0] i_box_ymax;
  logic [FEAT_W-1:0]  o_char1;
  logic               o_char_vld;
  logic               o_err;

  modport master (
    output i_vsync_pos, i_de, i_bin, i_box_xmin, i_box_xmax, i_box_ymin, i_box_ymax,
    input  o_char1, o_char_vld, o_err
  );

  modport slave (
    input  i_vsync_pos, i_de, i_bin, i_box_xmin, i_box_xmax, i_box_ymin, i_box_ymax,
    output o_char1, o_char_vld, o_err
  );

endinterface

// File: rtl/char_grid_feature_grid_step_acc.sv
// Bresenham step accumulator: idx = floor(k*STEP/span) after k advances, no divider.
module grid_step_acc
  import char_grid_feature_pkg::*;
#(
  parameter int unsigned STEP   = 5,
  parameter int unsigned SPAN_W = 13,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [SPAN_W-1:0] span,
  output logic [IDX_W-1:0]  idx,
  output logic              wrap_c
);

  logic [SPAN_W-1:0] acc;
  logic [SPAN_W:0]   sum;

  assign sum    = {1'b0, acc} + (SPAN_W + 1)'(STEP);
  assign wrap_c = adv && (sum >= {1'b0, span});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      idx <= '0;
    end else if (adv) begin
      if (wrap_c) begin
        acc <= SPAN_W'(sum - {1'b0, span});
        idx <= idx + IDX_W'(1);
      end else begin
        acc <= SPAN_W'(sum);
      end
    end
  end

endmodule

// File: rtl/char_grid_feature.sv
// 5x8 grid-occupancy feature extractor over a glyph bounding box in a binarized pixel stream.
// Optional macro CHAR_GRID_EMPTY_CHECK_EN rejects completed frames with no foreground pixel.
module char_grid_feature
  import char_grid_feature_pkg::*;
#(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned CNT_W   = 20
) (
  input logic                pixelclk,
  input logic                reset,
  char_grid_feature_if.slave bus
);

  localparam int unsigned SPAN_W = COORD_W + 1;

  state_t               state, state_nxt;
  logic                 de_d;
  logic [COORD_W-1:0]   x_cnt, y_cnt;
  logic [COORD_W-1:0]   box_xmin, box_xmax, box_ymin, box_ymax;
  logic [SPAN_W-1:0]    box_w, box_h, in_w, in_h;
  logic [CNT_W-1:0]     fg_cnt  [GRID_COLS];
  logic [CNT_W-1:0]     tot_cnt [GRID_COLS];
  logic [FEAT_W-1:0]    shadow, shadow_nxt, feature;
  logic [GRID_COLS-1:0] band_bits;
  logic [IDX_W-1:0]     col, row;
  logic                 row_wrap, unused_col_wrap;
  logic                 vsync, de, line_end, box_ok, scan_act, pix_in;
  logic                 scan_line_end, last_line, band_close, frame_done;
  logic                 vld, err, vld_c, err_c;
`ifdef CHAR_GRID_EMPTY_CHECK_EN
  logic                 any_fg;
`endif

  assign vsync    = bus.i_vsync_pos;
  assign de       = bus.i_de;
  assign line_end = de_d & ~de;

  // Box validity checked on the raw inputs; inverted bounds are rejected before width wraps.
  assign in_w   = SPAN_W'(bus.i_box_xmax) - SPAN_W'(bus.i_box_xmin) + SPAN_W'(1);
  assign in_h   = SPAN_W'(bus.i_box_ymax) - SPAN_W'(bus.i_box_ymin) + SPAN_W'(1);
  assign box_ok = (bus.i_box_xmax >= bus.i_box_xmin) && (in_w >= SPAN_W'(GRID_COLS)) &&
                  (bus.i_box_ymax >= bus.i_box_ymin) && (in_h >= SPAN_W'(GRID_ROWS));

  // Count the first box line even if it begins in the cycle WAIT_BOX hands over to SCAN.
  assign scan_act      = (state == SCAN) || ((state == WAIT_BOX) && (y_cnt == box_ymin));
  assign pix_in        = ~vsync & de & scan_act & (x_cnt >= box_xmin) & (x_cnt <= box_xmax);
  assign scan_line_end = ~vsync & line_end & (state == SCAN);
  assign last_line     = (y_cnt == box_ymax);
  assign band_close    = scan_line_end & (row_wrap | last_line);
  assign frame_done    = scan_line_end & last_line;

  grid_step_acc #(.STEP(GRID_COLS), .SPAN_W(SPAN_W), .IDX_W(IDX_W)) u_col_acc (
    .clk(pixelclk), .rst(reset), .clr(vsync | ~de), .adv(pix_in),
    .span(box_w), .idx(col), .wrap_c(unused_col_wrap)
  );

  grid_step_acc #(.STEP(GRID_ROWS), .SPAN_W(SPAN_W), .IDX_W(IDX_W)) u_row_acc (
    .clk(pixelclk), .rst(reset), .clr(vsync), .adv(scan_line_end),
    .span(box_h), .idx(row), .wrap_c(row_wrap)
  );

  always_ff @(posedge pixelclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vsync) begin
      state_nxt = box_ok ? WAIT_BOX : IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        WAIT_BOX: if (y_cnt == box_ymin) state_nxt = SCAN;
        SCAN:     if (line_end && last_line) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    vld_c = 1'b0;
    err_c = 1'b0;
    if (vsync) begin
      err_c = ~box_ok;
    end else if (frame_done) begin
`ifdef CHAR_GRID_EMPTY_CHECK_EN
      vld_c = any_fg;
      err_c = ~any_fg;
`else
      vld_c = 1'b1;
`endif
    end
  end

  // Majority decision per column cell merged into the shadow at the current band row.
  always_comb begin
    shadow_nxt = shadow;
    band_bits  = '0;
    for (int unsigned c = 0; c < GRID_COLS; c++) begin
      band_bits[c] = {fg_cnt[c], 1'b0} > {1'b0, tot_cnt[c]};
      if (row < IDX_W'(GRID_ROWS)) shadow_nxt[BIT_W'(bit_idx(32'(row), c))] = band_bits[c];
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      de_d     <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      box_xmin <= '0;
      box_xmax <= '0;
      box_ymin <= '0;
      box_ymax <= '0;
      box_w    <= '0;
      box_h    <= '0;
      shadow   <= '0;
      feature  <= '0;
      vld      <= 1'b0;
      err      <= 1'b0;
      for (int unsigned c = 0; c < GRID_COLS; c++) begin
        fg_cnt[c]  <= '0;
        tot_cnt[c] <= '0;
      end
    end else begin
      de_d  <= de;
      x_cnt <= (de && !vsync) ? x_cnt + COORD_W'(1) : '0;
      if (vsync)         y_cnt <= '0;
      else if (line_end) y_cnt <= y_cnt + COORD_W'(1);

      if (vsync) begin
        box_xmin <= bus.i_box_xmin;
        box_xmax <= bus.i_box_xmax;
        box_ymin <= bus.i_box_ymin;
        box_ymax <= bus.i_box_ymax;
        box_w    <= in_w;
        box_h    <= in_h;
        shadow   <= '0;
        for (int unsigned c = 0; c < GRID_COLS; c++) begin
          fg_cnt[c]  <= '0;
          tot_cnt[c] <= '0;
        end
      end else if (band_close) begin
        shadow <= shadow_nxt;
        for (int unsigned c = 0; c < GRID_COLS; c++) begin
          fg_cnt[c]  <= '0;
          tot_cnt[c] <= '0;
        end
      end else if (pix_in) begin
        for (int unsigned c = 0; c < GRID_COLS; c++) begin
          if (col == IDX_W'(c)) begin
            tot_cnt[c] <= tot_cnt[c] + CNT_W'(1);
            fg_cnt[c]  <= fg_cnt[c] + CNT_W'(bus.i_bin);
          end
        end
      end

      if (vld_c) feature <= shadow_nxt;
      vld <= vld_c;
      err <= err_c;
    end
  end

`ifdef CHAR_GRID_EMPTY_CHECK_EN
  always_ff @(posedge pixelclk) begin
    if (reset || vsync)          any_fg <= 1'b0;
    else if (pix_in && bus.i_bin) any_fg <= 1'b1;
  end
`endif

  assign bus.o_char1    = feature;
  assign bus.o_char_vld = vld;
  assign bus.o_err      = err;

endmodule

// File: tb/tb_char_grid_feature.sv
// Self-checking bench for char_grid_feature: directed frames plus random boxes/images vs a cell-count model.
module tb_char_grid_feature;

  localparam int unsigned COORD_W = 12;
  localparam int FW = 44;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   vld_cnt = 0;
  int   err_cnt = 0;
  int   vld_cyc = -1;
  int   err_cyc = -1;
  bit   img [64][48];

  char_grid_feature_if #(.COORD_W(COORD_W)) bus ();

  char_grid_feature #(.COORD_W(COORD_W), .CNT_W(20)) dut (
    .pixelclk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_char_vld === 1'b1) begin vld_cnt++; vld_cyc = cyc; end
    if (bus.o_err === 1'b1)      begin err_cnt++; err_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input int mode, input int dens);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 48; x++)
        case (mode)
          0:       img[y][x] = 1'b1;
          1:       img[y][x] = (x <= 4);
          2:       img[y][x] = 1'b0;
          default: img[y][x] = (int'($urandom_range(0, 99)) < dens);
        endcase
  endtask

  // Reference: count every box pixel straight into cell (floor(8j/H), floor(5i/W)).
  function automatic logic [39:0] model(input int xmin, input int xmax, input int ymin, input int ymax);
    int fg [8][5];
    int tot [8][5];
    int w, h, r, c;
    logic [39:0] v;
    w = xmax - xmin + 1;
    h = ymax - ymin + 1;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 5; j++) begin fg[i][j] = 0; tot[i][j] = 0; end
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        r = ((y - ymin) * 8) / h;
        c = ((x - xmin) * 5) / w;
        tot[r][c]++;
        if (img[y][x]) fg[r][c]++;
      end
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 5; j++)
        v[39 - (5 * i + j)] = (2 * fg[i][j] > tot[i][j]);
    return v;
  endfunction

  task automatic run_frame(input int xmin, input int xmax, input int ymin, input int ymax,
                           input int nlines, input bit vs_end, output int n_cyc, output int vs_cyc);
    n_cyc = -1;
    tick();
    bus.i_vsync_pos = 1'b1;
    bus.i_box_xmin  = COORD_W'(xmin);
    bus.i_box_xmax  = COORD_W'(xmax);
    bus.i_box_ymin  = COORD_W'(ymin);
    bus.i_box_ymax  = COORD_W'(ymax);
    vs_cyc = cyc;
    tick();
    bus.i_vsync_pos = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < FW; x++) begin
        tick();
        bus.i_de  = 1'b1;
        bus.i_bin = img[y][x];
      end
      tick();
      bus.i_de  = 1'b0;
      bus.i_bin = 1'b0;
      if (y == ymax) begin
        n_cyc = cyc;
        if (vs_end) bus.i_vsync_pos = 1'b1;
      end
      tick();
      bus.i_vsync_pos = 1'b0;
      repeat (HB - 2) tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.o_char1 !== 40'h0) begin errors++; $display("FAIL reset_char1: got %h expected 0", bus.o_char1); end
    checks++; if (bus.o_char_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.o_char_vld); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_fg();
    int n, vs, v0;
    fill_img(0, 0);
    v0 = vld_cnt;
    run_frame(0, 9, 0, 15, 17, 1'b0, n, vs);
    checks++; if (bus.o_char1 !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL full_char1: got %h expected ffffffffff", bus.o_char1); end
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL full_vld_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (vld_cyc != n + 1) begin errors++; $display("FAIL full_vld_cycle: got %0d expected %0d", vld_cyc, n + 1); end
  endtask

  task automatic test_tie();
    int n, vs, v0;
    fill_img(1, 0);
    v0 = vld_cnt;
    run_frame(0, 9, 0, 15, 17, 1'b0, n, vs);
    checks++; if (bus.o_char1 !== 40'hC6_318C_6318) begin errors++; $display("FAIL tie_char1: got %h expected c6318c6318", bus.o_char1); end
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL tie_vld_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (vld_cyc != n + 1) begin errors++; $display("FAIL tie_vld_cycle: got %0d expected %0d", vld_cyc, n + 1); end
  endtask

  task automatic test_reject();
    int n, vs, v0, e0;
    logic [39:0] prev;
    fill_img(0, 0);
    prev = bus.o_char1;
    v0 = vld_cnt; e0 = err_cnt;
    run_frame(0, 3, 0, 15, 17, 1'b0, n, vs);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL rej_w_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (err_cyc != vs + 1) begin errors++; $display("FAIL rej_w_err_cycle: got %0d expected %0d", err_cyc, vs + 1); end
    checks++; if (vld_cnt - v0 != 0) begin errors++; $display("FAIL rej_w_vld_count: got %0d expected 0", vld_cnt - v0); end
    checks++; if (bus.o_char1 !== prev) begin errors++; $display("FAIL rej_w_char1: got %h expected %h", bus.o_char1, prev); end
    v0 = vld_cnt; e0 = err_cnt;
    run_frame(2, 20, 2, 8, 10, 1'b0, n, vs);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL rej_h_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (vld_cnt - v0 != 0) begin errors++; $display("FAIL rej_h_vld_count: got %0d expected 0", vld_cnt - v0); end
  endtask

  task automatic test_abort();
    int n, vs, v0, e0;
    logic [39:0] exp, prev;
    fill_img(0, 0);
    v0 = vld_cnt;
    run_frame(0, 9, 0, 15, 7, 1'b0, n, vs);
    fill_img(3, 50);
    img[0][1] = 1'b1;
    exp = model(1, 22, 0, 15);
    run_frame(1, 22, 0, 15, 17, 1'b0, n, vs);
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL abort_vld_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (bus.o_char1 !== exp) begin errors++; $display("FAIL abort_next_char1: got %h expected %h", bus.o_char1, exp); end
    checks++; if (vld_cyc != n + 1) begin errors++; $display("FAIL abort_next_vld_cycle: got %0d expected %0d", vld_cyc, n + 1); end
    fill_img(0, 0);
    prev = bus.o_char1;
    v0 = vld_cnt; e0 = err_cnt;
    run_frame(0, 9, 0, 15, 17, 1'b1, n, vs);
    checks++; if (vld_cnt - v0 != 0) begin errors++; $display("FAIL vs_end_vld_count: got %0d expected 0", vld_cnt - v0); end
    checks++; if (bus.o_char1 !== prev) begin errors++; $display("FAIL vs_end_char1: got %h expected %h", bus.o_char1, prev); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL vs_end_err_count: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_empty();
    int n, vs, v0, e0;
    logic [39:0] prev;
    fill_img(2, 0);
    prev = bus.o_char1;
    v0 = vld_cnt; e0 = err_cnt;
    run_frame(0, 9, 0, 15, 17, 1'b0, n, vs);
`ifdef CHAR_GRID_EMPTY_CHECK_EN
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL empty_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (err_cyc != n + 1) begin errors++; $display("FAIL empty_err_cycle: got %0d expected %0d", err_cyc, n + 1); end
    checks++; if (vld_cnt - v0 != 0) begin errors++; $display("FAIL empty_vld_count: got %0d expected 0", vld_cnt - v0); end
    checks++; if (bus.o_char1 !== prev) begin errors++; $display("FAIL empty_char1: got %h expected %h", bus.o_char1, prev); end
`else
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL empty_vld_count: got %0d expected 1", vld_cnt - v0); end
    checks++; if (vld_cyc != n + 1) begin errors++; $display("FAIL empty_vld_cycle: got %0d expected %0d", vld_cyc, n + 1); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL empty_err_count: got %0d expected 0 (prev %h)", err_cnt - e0, prev); end
    checks++; if (bus.o_char1 !== 40'h0) begin errors++; $display("FAIL empty_char1: got %h expected 0", bus.o_char1); end
`endif
  endtask

  task automatic test_random();
    int n, vs, v0, xmin, xmax, ymin, ymax;
    logic [39:0] exp;
    for (int f = 0; f < 8; f++) begin
      xmin = $urandom_range(0, 10);
      ymin = $urandom_range(0, 6);
      xmax = xmin + ((f == 0) ? 5 : $urandom_range(5, 30)) - 1;
      ymax = ymin + ((f == 0) ? 8 : $urandom_range(8, 24)) - 1;
      fill_img(3, $urandom_range(20, 80));
      img[ymin][xmin] = 1'b1;
      exp = model(xmin, xmax, ymin, ymax);
      v0 = vld_cnt;
      run_frame(xmin, xmax, ymin, ymax, ymax + 2, 1'b0, n, vs);
      checks++; if (bus.o_char1 !== exp) begin errors++; $display("FAIL rand%0d_char1: got %h expected %h", f, bus.o_char1, exp); end
      checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL rand%0d_vld_count: got %0d expected 1", f, vld_cnt - v0); end
      checks++; if (vld_cyc != n + 1) begin errors++; $display("FAIL rand%0d_vld_cycle: got %0d expected %0d", f, vld_cyc, n + 1); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n, vs, v0;
    fill_img(0, 0);
    run_frame(0, 9, 0, 15, 5, 1'b0, n, vs);
    rst = 1'b1;
    tick();
    checks++; if (bus.o_char1 !== 40'h0) begin errors++; $display("FAIL midrst_char1: got %h expected 0", bus.o_char1); end
    checks++; if (bus.o_char_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", bus.o_char_vld); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", bus.o_err); end
    rst = 1'b0;
    tick();
    v0 = vld_cnt;
    run_frame(0, 9, 0, 15, 17, 1'b0, n, vs);
    checks++; if (bus.o_char1 !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL midrst_next_char1: got %h expected ffffffffff", bus.o_char1); end
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL midrst_next_vld_count: got %0d expected 1", vld_cnt - v0); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_vsync_pos = 1'b0;
    bus.i_de        = 1'b0;
    bus.i_bin       = 1'b0;
    bus.i_box_xmin  = '0;
    bus.i_box_xmax  = '0;
    bus.i_box_ymin  = '0;
    bus.i_box_ymax  = '0;
    test_reset();
    test_full_fg();
    test_tie();
    test_reject();
    test_abort();
    test_empty();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
